inv_key_scheduler: RTL and testbench

Decryption-side key scheduler for the BORON datapath: 80-bit master key, 64-bit block, 25 rounds. It loads the master key and expands it forward through all 25 key-schedule steps. It then streams the 64-bit round keys back out in reverse order (K25 down to K0) over a valid/ready interface, undoing one schedule step per accepted key. It feeds the decryption round datapath, mirroring what `key_scheduler` does for encryption.

---
 rtl/inv_key_scheduler_if.sv | 43 ++++
 rtl/inv_key_scheduler.sv | 137 +++++++++++++
 tb/tb_inv_key_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_scheduler_if.sv
// ---------------------------------------------------------------------------
// inv_key_scheduler_if
// Bundles the load request and the round-key stream of inv_key_scheduler.
//
// Signals:
//   i_start     load request (seen only while the scheduler is idle)
//   i_key       80-bit master key K0
//   o_busy      scheduler is expanding or emitting
//   o_rk_valid  o_rk / o_round / o_last carry a key
//   i_rk_ready  consumer accepts the current key
//   o_rk        64-bit round key
//   o_round     round index of o_rk (ROUNDS down to 0)
//   o_last      current key is round 0
//   dbg_state   FSM state (0 idle, 1 expand, 2 emit)
//
// Handshake: a key moves on a rising edge where o_rk_valid and i_rk_ready
// are both high. Once o_rk_valid rises it stays high, and o_rk, o_round and
// o_last stay unchanged, until that transfer happens.
//
// Modports: slave = the scheduler, master = the side that loads keys and
// consumes round keys.
// ---------------------------------------------------------------------------
interface inv_key_scheduler_if;
    logic        i_start;
    logic [79:0] i_key;
    logic        o_busy;
    logic        o_rk_valid;
    logic        i_rk_ready;
    logic [63:0] o_rk;
    logic [4:0]  o_round;
    logic        o_last;
    logic [1:0]  dbg_state;

    modport slave (
        input  i_start, i_key, i_rk_ready,
        output o_busy, o_rk_valid, o_rk, o_round, o_last, dbg_state
    );

    modport master (
        output i_start, i_key, i_rk_ready,
        input  o_busy, o_rk_valid, o_rk, o_round, o_last, dbg_state
    );
endinterface

// File: rtl/inv_key_scheduler.sv
// ---------------------------------------------------------------------------
// inv_key_scheduler
// Decryption-side key scheduler for the BORON datapath (80-bit key, 64-bit
// block). After a load, the master key is walked forward through all ROUNDS
// schedule steps. The round keys are then streamed out from K_ROUNDS down to
// K0, undoing one schedule step per accepted key. Only the current 80-bit key
// is kept; earlier keys are regenerated rather than stored.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; wins over everything
//   bus  inv_key_scheduler_if.slave (load request and round-key stream)
// ---------------------------------------------------------------------------
module inv_key_scheduler #(
    parameter int ROUNDS = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_key_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    state_t      state;
    logic [79:0] key_reg;
    logic [4:0]  rnd;
    logic        busy_q;
    logic        valid_q;

    logic [79:0] fwd_key;
    logic [79:0] inv_key;

    function automatic logic [3:0] s_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_s_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
            4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
            4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
            4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
        endcase
        return y;
    endfunction

    // F(K, r): rotate left 13, substitute the low nibble, mix (r-1) into [63:59].
    function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t         = {k[66:0], k[79:67]};
        t[3:0]    = s_box(t[3:0]);
        t[63:59]  = t[63:59] ^ (r - 5'd1);
        return t;
    endfunction

    // G(K, r): undo F in reverse order. The nibble and the counter field do
    // not overlap, so only the rotation has to come last.
    function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t         = k;
        t[63:59]  = t[63:59] ^ (r - 5'd1);
        t[3:0]    = inv_s_box(t[3:0]);
        return {t[12:0], t[79:13]};
    endfunction

    always_comb begin
        fwd_key = fwd_step(key_reg, rnd);
        inv_key = inv_step(key_reg, rnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_reg <= '0;
            rnd     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        key_reg <= bus.i_key;
                        rnd     <= 5'd1;
                        busy_q  <= 1'b1;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_reg <= fwd_key;
                    if (rnd == LAST_RND) begin
                        // rnd already names the key now in key_reg.
                        valid_q <= 1'b1;
                        state   <= EMIT;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                EMIT: begin
                    if (bus.i_rk_ready) begin
                        if (rnd != 5'd0) begin
                            key_reg <= inv_key;
                            rnd     <= rnd - 5'd1;
                        end else begin
                            // key_reg is back at K0 here; it is left as is.
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_rk_valid = valid_q;
    assign bus.o_rk       = key_reg[63:0];
    assign bus.o_round    = rnd;
    assign bus.o_last     = valid_q && (rnd == 5'd0);
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_inv_key_scheduler
// Bench for inv_key_scheduler. A forward key chain K0..K25 is built from
// the schedule definition and its low halves are queued K25 first; the
// emitted stream is checked against that queue.
// ---------------------------------------------------------------------------
module tb_inv_key_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_key_scheduler_if bus();

    inv_key_scheduler #(.ROUNDS(25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    logic [79:0] chain [0:25];

    localparam logic [79:0] XKEY = 80'h0123456789ABCDEF0123;

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_sbox(input logic [3:0] x);
        logic [3:0] tbl [0:15];
        tbl = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
        return tbl[x];
    endfunction

    function automatic logic [79:0] model_fwd(input logic [79:0] k, input int r);
        logic [79:0] t;
        t        = (k << 13) | (k >> 67);
        t[3:0]   = model_sbox(t[3:0]);
        t[63:59] = t[63:59] ^ 5'(r - 1);
        return t;
    endfunction

    task automatic build_chain(input logic [79:0] key);
        chain[0] = key;
        for (int r = 1; r <= 25; r++) chain[r] = model_fwd(chain[r-1], r);
        exp_q.delete();
        for (int r = 25; r >= 0; r--) exp_q.push_back(chain[r][63:0]);
    endtask

    function automatic logic [79:0] rand_key();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    // Entered at a falling edge; returns at the falling edge after the accept edge.
    task automatic do_start(input logic [79:0] key);
        bus.i_start = 1'b1;
        bus.i_key   = key;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b expected 1", bus.o_busy);
        end
    endtask

    // Counts edges from the accept edge to the first valid key.
    task automatic wait_first_key(input bit poke);
        int lat = 0;
        while (!bus.o_rk_valid && lat < 100) begin
            if (poke && lat == 5) begin
                bus.i_start = 1'b1;
                bus.i_key   = rand_key();
            end else begin
                bus.i_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.i_start = 1'b0;
        n_cmp++;
        if (lat != 25) begin
            n_bad++;
            $display("FAIL first_key_latency: got %0d cycles expected 25", lat);
        end
    endtask

    task automatic reset_pulse_check(input string tag);
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_rk_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_busy, bus.o_rk_valid, bus.o_rk, bus.o_round, bus.o_last, bus.dbg_state} !== '0) begin
            n_bad++;
            $display("FAIL reset_%s: got busy=%b valid=%b rk=%h round=%0d last=%b state=%0d expected all 0",
                     tag, bus.o_busy, bus.o_rk_valid, bus.o_rk, bus.o_round, bus.o_last, bus.dbg_state);
        end
        rst = 1'b0;
    endtask

    // Drains the expected queue. duty = percent chance of ready per cycle.
    // poke pulses i_start on the round-12 and round-0 transfers.
    // rst_round >= 0 aborts with a reset when that round is presented.
    task automatic collect(input int duty, input bit poke, input int rst_round,
                           output logic [63:0] last_rk);
        int          exp_round = 25;
        int          guard = 0;
        bit          stalled = 0;
        bit          go;
        bit          aborted = 0;
        logic [63:0] held_rk = '0;
        logic [4:0]  held_round = '0;
        logic        held_last = 1'b0;
        logic [63:0] e;
        last_rk = '0;
        while (exp_q.size() > 0 && guard < 3000) begin
            if (stalled) begin
                n_cmp++;
                if (bus.o_rk_valid !== 1'b1 || bus.o_rk !== held_rk ||
                    bus.o_round !== held_round || bus.o_last !== held_last) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%b rk=%h round=%0d last=%b expected 1 %h %0d %b",
                             bus.o_rk_valid, bus.o_rk, bus.o_round, bus.o_last,
                             held_rk, held_round, held_last);
                end
            end
            if (rst_round >= 0 && bus.o_rk_valid && int'(bus.o_round) == rst_round) begin
                reset_pulse_check("emit");
                exp_q.delete();
                aborted = 1;
                break;
            end
            if (bus.o_rk_valid !== 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_during_emit: got %b expected 1 (round %0d)", bus.o_rk_valid, exp_round);
            end
            go = ($urandom_range(99) < duty);
            bus.i_start = 1'b0;
            if (go && bus.o_rk_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.o_rk !== e || bus.o_round !== 5'(exp_round) || bus.o_last !== (exp_round == 0)) begin
                    n_bad++;
                    $display("FAIL round_key: got rk=%h round=%0d last=%b expected %h %0d %b",
                             bus.o_rk, bus.o_round, bus.o_last, e, exp_round, (exp_round == 0));
                end
                last_rk = bus.o_rk;
                if (poke && (exp_round == 12 || exp_round == 0)) begin
                    bus.i_start = 1'b1;
                    bus.i_key   = rand_key();
                end
                exp_round--;
                stalled = 0;
            end else begin
                stalled    = 1;
                held_rk    = bus.o_rk;
                held_round = bus.o_round;
                held_last  = bus.o_last;
            end
            bus.i_rk_ready = go;
            @(negedge clk);
            guard++;
        end
        bus.i_rk_ready = 1'b0;
        bus.i_start    = 1'b0;
        if (guard >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL emit_timeout: got %0d keys left expected 0", exp_q.size());
        end
        if (!aborted) begin
            n_cmp++;
            if (bus.o_rk_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL end_of_run: got valid=%b busy=%b expected 0 0", bus.o_rk_valid, bus.o_busy);
            end
        end
    endtask

    task automatic full_run(input logic [79:0] key, input int duty, output logic [63:0] last_rk);
        build_chain(key);
        do_start(key);
        wait_first_key(1'b0);
        collect(duty, 1'b0, -1, last_rk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] lr;
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_key      = '0;
        bus.i_rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_pulse_check("initial");
        lr = '0;
    endtask

    task automatic test_zero_key();
        logic [63:0] lr;
        full_run(80'h0, 100, lr);
        n_cmp++;
        if (lr !== 64'h0) begin
            n_bad++;
            $display("FAIL zero_key_last: got %h expected 0", lr);
        end
    endtask

    task automatic test_cross_check();
        logic [63:0] lr;
        full_run(XKEY, 100, lr);
        n_cmp++;
        if (lr !== 64'h456789ABCDEF0123) begin
            n_bad++;
            $display("FAIL cross_check_last: got %h expected 456789abcdef0123", lr);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] lr;
        full_run(XKEY, 30, lr);
    endtask

    task automatic test_start_while_busy();
        logic [63:0] lr;
        build_chain(XKEY);
        do_start(XKEY);
        wait_first_key(1'b1);
        collect(70, 1'b1, -1, lr);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_rk_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL start_on_final_handshake: got busy=%b valid=%b expected 0 0",
                     bus.o_busy, bus.o_rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] lr;
        logic [79:0] k;
        // Reset while expanding round 10.
        k = rand_key();
        build_chain(k);
        do_start(k);
        repeat (9) @(negedge clk);
        reset_pulse_check("expand");
        full_run(rand_key(), 100, lr);
        // Reset while round 12 is on the output.
        k = rand_key();
        build_chain(k);
        do_start(k);
        wait_first_key(1'b0);
        collect(100, 1'b0, 12, lr);
        full_run(rand_key(), 60, lr);
    endtask

    task automatic test_random_keys();
        logic [63:0] lr;
        for (int i = 0; i < 6; i++) full_run(rand_key(), $urandom_range(100, 40), lr);
    endtask

    task automatic test_back_to_back();
        logic [63:0] lr;
        time t0;
        time t1;
        t0 = $time;
        full_run(rand_key(), 100, lr);
        t1 = $time;
        n_cmp++;
        if (t1 - t0 != 520) begin
            n_bad++;
            $display("FAIL start_spacing: got %0t expected 520 (52 cycles)", t1 - t0);
        end
        full_run(XKEY, 100, lr);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_key();
        test_cross_check();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_random_keys();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
